serial_subtract_ctrl: RTL and testbench

Bit-serial multi-bit subtractor controller. It computes diff = a - b for WIDTH-bit unsigned operands, LSB first, one bit per clock. It reuses one full-subtract cell built from two halfsubtract instances. It sits between a requester using a start/done handshake and the half-subtract datapath, and sequences operand shifting, borrow propagation and result collection.

---
 rtl/serial_subtract_ctrl_pkg.sv | 14 +
 rtl/serial_subtract_ctrl_if.sv | 31 +++
 rtl/full_subtract_cell.sv | 17 +
 rtl/halfsubtract.sv | 10 +
 rtl/serial_subtract_defs.vh | 10 +
 rtl/serial_subtract_ctrl.sv | 103 ++++++++++
 tb/tb_serial_subtract_ctrl.sv | 193 +++++++++++++++++++
 7 files changed

// File: rtl/serial_subtract_ctrl_pkg.sv
// Common types for the serial subtractor controller.
`include "serial_subtract_defs.vh"

package serial_subtract_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = `SERSUB_ST_IDLE,
      RUN  = `SERSUB_ST_RUN,
      DONE = `SERSUB_ST_DONE
   } state_t;

   localparam int DEFAULT_WIDTH = `SERSUB_DEFAULT_WIDTH;

endpackage

// File: rtl/serial_subtract_ctrl_if.sv
// Requester-side bundle of the serial subtractor; ovf exists only with SERSUB_OVERFLOW_EN.
`include "serial_subtract_defs.vh"

interface serial_subtract_ctrl_if #(parameter int WIDTH = `SERSUB_DEFAULT_WIDTH);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
`ifdef SERSUB_OVERFLOW_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b,
`ifdef SERSUB_OVERFLOW_EN
      input  ovf,
`endif
      input  busy, done, diff, borrow_out
   );

   modport slave (
      input  start, a, b,
`ifdef SERSUB_OVERFLOW_EN
      output ovf,
`endif
      output busy, done, diff, borrow_out
   );
endinterface

// File: rtl/full_subtract_cell.sv
// One-bit full subtractor from two cascaded half subtractors: d = x - y - bin.
module full_subtract_cell (
   output logic d,
   output logic bout,
   input  logic x,
   input  logic y,
   input  logic bin
);
   logic d1;
   logic borrow1;
   logic borrow2;

   halfsubtract u_hs0 (.x(x),  .y(y),   .d(d1), .borrow(borrow1));
   halfsubtract u_hs1 (.x(d1), .y(bin), .d(d),  .borrow(borrow2));

   assign bout = borrow1 | borrow2;
endmodule

// File: rtl/halfsubtract.sv
// One-bit half subtractor: d = x - y, borrow when x < y.
module halfsubtract (
   input  logic x,
   input  logic y,
   output logic d,
   output logic borrow
);
   assign d      = x ^ y;
   assign borrow = ~x & y;
endmodule

// File: rtl/serial_subtract_defs.vh
// Shared state encodings and default operand width for the serial subtractor.
`ifndef SERIAL_SUBTRACT_DEFS_VH
`define SERIAL_SUBTRACT_DEFS_VH

`define SERSUB_ST_IDLE 2'd0
`define SERSUB_ST_RUN  2'd1
`define SERSUB_ST_DONE 2'd2
`define SERSUB_DEFAULT_WIDTH 8

`endif

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial a - b, LSB first, one bit per clock; result after WIDTH+1 cycles.
// Optional SERSUB_OVERFLOW_EN adds a signed-overflow flag alongside diff.
`include "serial_subtract_defs.vh"

module serial_subtract_ctrl
   import serial_subtract_ctrl_pkg::*;
#(
   parameter int WIDTH = `SERSUB_DEFAULT_WIDTH,
   parameter int CNT_W = 5
) (
   input logic                clk,
   input logic                rst,
   serial_subtract_ctrl_if.slave bus
);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-2:0]   diff_sr;
   logic [WIDTH-1:0]   diff_nxt;
   logic [WIDTH-1:0]   diff_q;
   logic [CNT_W-1:0]   cnt;
   logic               borrow_reg;
   logic               borrow_q;
   logic               cell_d;
   logic               cell_bout;
   logic               last_bit;

   full_subtract_cell u_cell (
      .d    (cell_d),
      .bout (cell_bout),
      .x    (a_sr[0]),
      .y    (b_sr[0]),
      .bin  (borrow_reg)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));
   // The newest bit enters at the MSB; after WIDTH shifts bit 0 holds the first result bit.
   assign diff_nxt = {cell_d, diff_sr};

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last_bit)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr       <= '0;
         b_sr       <= '0;
         diff_sr    <= '0;
         cnt        <= '0;
         borrow_reg <= 1'b0;
         diff_q     <= '0;
         borrow_q   <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         a_sr       <= bus.a;
         b_sr       <= bus.b;
         borrow_reg <= 1'b0;
         cnt        <= '0;
      end else if (state == RUN) begin
         a_sr       <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr       <= {1'b0, b_sr[WIDTH-1:1]};
         diff_sr    <= diff_nxt[WIDTH-1:1];
         borrow_reg <= cell_bout;
         cnt        <= cnt + CNT_W'(1);
         if (last_bit) begin
            diff_q   <= diff_nxt;
            borrow_q <= cell_bout;
         end
      end
   end

`ifdef SERSUB_OVERFLOW_EN
   logic ovf_q;

   // On the final bit the cell inputs are the operand MSBs and cell_d is the result MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf_q <= 1'b0;
      else if (state == RUN && last_bit)
         ovf_q <= (a_sr[0] != b_sr[0]) && (cell_d != a_sr[0]);
   end

   assign bus.ovf = ovf_q;
`endif

   assign bus.busy       = (state == RUN) || (state == DONE);
   assign bus.done       = (state == DONE);
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Directed bench for serial_subtract_ctrl (WIDTH=8); ovf checks under SERSUB_OVERFLOW_EN.
module tb_serial_subtract_ctrl;

   logic clk;
   logic rst;
   int   pass_cnt;
   int   total_cnt;

   serial_subtract_ctrl_if #(.WIDTH(8)) bus ();

   serial_subtract_ctrl #(.WIDTH(8), .CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts one operation from IDLE and returns once the block is idle again.
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                         output int lat, output int busy_cyc, output int done_cyc);
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      tick();
      bus.start = 1'b0;
      bus.a     = ~av;
      bus.b     = ~bv;
      lat = 0; busy_cyc = 0; done_cyc = 0;
      for (int c = 1; c <= 30; c++) begin
         if (bus.busy) busy_cyc++;
         if (bus.done) begin
            done_cyc++;
            if (lat == 0) lat = c;
         end
         if (!bus.busy) break;
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.a = 8'h00;
      bus.b = 8'h00;
      tick();
      tick();
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.done); else pass_cnt++;
      total_cnt++; if (bus.diff !== 8'h00) $display("FAIL reset_diff got %h exp 00", bus.diff); else pass_cnt++;
      total_cnt++; if (bus.borrow_out !== 1'b0) $display("FAIL reset_borrow got %b exp 0", bus.borrow_out); else pass_cnt++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int lat, bc, dc;
      run_op(8'h35, 8'h12, lat, bc, dc);
      total_cnt++; if (lat !== 9) $display("FAIL basic_latency got %0d exp 9", lat); else pass_cnt++;
      total_cnt++; if (bc !== 9) $display("FAIL basic_busy_cycles got %0d exp 9", bc); else pass_cnt++;
      total_cnt++; if (dc !== 1) $display("FAIL basic_done_width got %0d exp 1", dc); else pass_cnt++;
      total_cnt++; if (bus.diff !== 8'h23) $display("FAIL basic_diff got %h exp 23", bus.diff); else pass_cnt++;
      total_cnt++; if (bus.borrow_out !== 1'b0) $display("FAIL basic_borrow got %b exp 0", bus.borrow_out); else pass_cnt++;
   endtask

   task automatic test_start_while_busy();
      int dn;
      dn = 0;
      bus.start = 1'b1;
      bus.a = 8'h35;
      bus.b = 8'h12;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         // a start pulse mid-RUN and another during the DONE cycle must both be dropped
         bus.start = (c == 3) || bus.done;
         if (c == 3) begin
            bus.a = 8'hFF;
            bus.b = 8'h00;
         end
         if (bus.done) dn++;
         tick();
      end
      bus.start = 1'b0;
      total_cnt++; if (dn !== 1) $display("FAIL ignore_done_count got %0d exp 1", dn); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL ignore_busy_after got %b exp 0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.diff !== 8'h23) $display("FAIL ignore_diff got %h exp 23", bus.diff); else pass_cnt++;
      tick();
   endtask

   task automatic test_overflow();
      int lat, bc, dc;
      run_op(8'h80, 8'h01, lat, bc, dc);
      total_cnt++; if (bus.diff !== 8'h7F) $display("FAIL ovf_case_diff got %h exp 7f", bus.diff); else pass_cnt++;
      total_cnt++; if (bus.borrow_out !== 1'b0) $display("FAIL ovf_case_borrow got %b exp 0", bus.borrow_out); else pass_cnt++;
`ifdef SERSUB_OVERFLOW_EN
      total_cnt++; if (bus.ovf !== 1'b1) $display("FAIL ovf_case_ovf got %b exp 1", bus.ovf); else pass_cnt++;
`endif
   endtask

   task automatic test_wrap();
      int lat, bc, dc;
      run_op(8'h00, 8'h01, lat, bc, dc);
      total_cnt++; if (bus.diff !== 8'hFF) $display("FAIL wrap_diff got %h exp ff", bus.diff); else pass_cnt++;
      total_cnt++; if (bus.borrow_out !== 1'b1) $display("FAIL wrap_borrow got %b exp 1", bus.borrow_out); else pass_cnt++;
      total_cnt++; if (lat !== 9) $display("FAIL wrap_latency got %0d exp 9", lat); else pass_cnt++;
`ifdef SERSUB_OVERFLOW_EN
      total_cnt++; if (bus.ovf !== 1'b0) $display("FAIL wrap_ovf got %b exp 0", bus.ovf); else pass_cnt++;
`endif
   endtask

   task automatic test_rst_mid();
      int dn, bz, lat, bc, dc;
      dn = 0; bz = 0;
      bus.start = 1'b1;
      bus.a = 8'h77;
      bus.b = 8'h11;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c < 4; c++) tick();
      #1 rst = 1'b1;
      #1;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.done !== 1'b0) $display("FAIL rstmid_done got %b exp 0", bus.done); else pass_cnt++;
      total_cnt++; if (bus.diff !== 8'h00) $display("FAIL rstmid_diff got %h exp 00", bus.diff); else pass_cnt++;
      total_cnt++; if (bus.borrow_out !== 1'b0) $display("FAIL rstmid_borrow got %b exp 0", bus.borrow_out); else pass_cnt++;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (bus.done) dn++;
         if (bus.busy) bz++;
         tick();
      end
      total_cnt++; if (dn !== 0) $display("FAIL rstmid_no_done got %0d exp 0", dn); else pass_cnt++;
      total_cnt++; if (bz !== 0) $display("FAIL rstmid_no_busy got %0d exp 0", bz); else pass_cnt++;
      run_op(8'h10, 8'h10, lat, bc, dc);
      total_cnt++; if (lat !== 9) $display("FAIL rstmid_next_latency got %0d exp 9", lat); else pass_cnt++;
      total_cnt++; if (bus.diff !== 8'h00) $display("FAIL rstmid_next_diff got %h exp 00", bus.diff); else pass_cnt++;
      total_cnt++; if (bus.borrow_out !== 1'b0) $display("FAIL rstmid_next_borrow got %b exp 0", bus.borrow_out); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int dcyc[3];
      int nd;
      int bz;
      nd = 0;
      dcyc[0] = 0; dcyc[1] = 0; dcyc[2] = 0;
      bus.start = 1'b1;
      bus.a = 8'h05;
      bus.b = 8'h03;
      tick();
      for (int c = 1; c <= 35; c++) begin
         if (bus.done && nd < 3) begin
            dcyc[nd] = c;
            nd++;
            total_cnt++; if (bus.diff !== 8'h02) $display("FAIL b2b_diff got %h exp 02 at cycle %0d", bus.diff, c); else pass_cnt++;
         end
         tick();
      end
      bus.start = 1'b0;
      total_cnt++; if (nd !== 3) $display("FAIL b2b_done_count got %0d exp 3", nd); else pass_cnt++;
      total_cnt++; if (dcyc[0] !== 9) $display("FAIL b2b_first_done got %0d exp 9", dcyc[0]); else pass_cnt++;
      total_cnt++; if (dcyc[1] - dcyc[0] !== 10) $display("FAIL b2b_period1 got %0d exp 10", dcyc[1] - dcyc[0]); else pass_cnt++;
      total_cnt++; if (dcyc[2] - dcyc[1] !== 10) $display("FAIL b2b_period2 got %0d exp 10", dcyc[2] - dcyc[1]); else pass_cnt++;
      bz = 1;
      for (int c = 0; c < 20 && bz == 1; c++) begin
         if (!bus.busy) bz = 0;
         else tick();
      end
      total_cnt++; if (bz !== 0) $display("FAIL b2b_drain got busy %0d exp 0", bz); else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_basic();
      test_start_while_busy();
      test_overflow();
      test_wrap();
      test_rst_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
